// File: rtl/ctrl_alu_stage_pkg.sv
// ctrl_alu_stage_pkg: opcode, funct, aluop and ALU control encodings shared by the decode/execute slice
package ctrl_alu_stage_pkg;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;
    localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
    localparam logic [3:0] ALUCTRL_OR   = 4'b0001;
    localparam logic [3:0] ALUCTRL_ADD  = 4'b0010;
    localparam logic [3:0] ALUCTRL_SUB  = 4'b0110;
    localparam logic [3:0] ALUCTRL_SLT  = 4'b0111;
    localparam logic [3:0] ALUCTRL_NOR  = 4'b1100;
    localparam logic [3:0] ALUCTRL_NONE = 4'b1111;
    typedef struct packed {
        logic       jump;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;
endpackage

// File: rtl/ctrl_alu_stage_alu_core.sv
// alu_core: combinational W-bit ALU; undefined control codes yield zero
module alu_core
    import ctrl_alu_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   aluctrl,
    output logic [W-1:0] result
);
    logic lt;
    assign lt = $signed(a) < $signed(b);
    always_comb begin
        result = '0;
        case (aluctrl)
            ALUCTRL_AND: result = a & b;
            ALUCTRL_OR:  result = a | b;
            ALUCTRL_ADD: result = a + b;
            ALUCTRL_SUB: result = a - b;
            ALUCTRL_SLT: result = {{(W-1){1'b0}}, lt};
            ALUCTRL_NOR: result = ~(a | b);
            default:     result = '0;
        endcase
    end
endmodule

// File: rtl/ctrl_alu_stage.sv
// ctrl_alu_stage: registered main decode, ALU control and execute slice with one-cycle latency
module ctrl_alu_stage
    import ctrl_alu_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] imm,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         jump,
    output logic         regdst,
    output logic         alusrc,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         memread,
    output logic         memwrite,
    output logic         branch,
    output logic [1:0]   aluop,
    output logic [3:0]   aluctrl
);
    ctrl_t        c, c_q;
    logic [3:0]   fn_ctrl, ac;
    logic [W-1:0] y;
    always_comb begin
        c = '0;
        case (op)
            OP_R:    begin c.regdst = 1'b1; c.regwrite = 1'b1; c.aluop = ALUOP_FUNCT; end
            OP_LW:   begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; end
            OP_SW:   begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
            OP_BEQ:  begin c.branch = 1'b1; c.aluop = ALUOP_SUB; end
            OP_ADDI: begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
            OP_J:    c.jump = 1'b1;
            default: c = '0;
        endcase
    end
    always_comb begin
        fn_ctrl = ALUCTRL_NONE;
        case (funct)
            FN_ADD:  fn_ctrl = ALUCTRL_ADD;
            FN_SUB:  fn_ctrl = ALUCTRL_SUB;
            FN_AND:  fn_ctrl = ALUCTRL_AND;
            FN_OR:   fn_ctrl = ALUCTRL_OR;
            FN_SLT:  fn_ctrl = ALUCTRL_SLT;
            FN_NOR:  fn_ctrl = ALUCTRL_NOR;
            default: fn_ctrl = ALUCTRL_NONE;
        endcase
    end
    assign ac = c.aluop == ALUOP_ADD ? ALUCTRL_ADD :
                c.aluop == ALUOP_SUB ? ALUCTRL_SUB :
                c.aluop == ALUOP_FUNCT ? fn_ctrl : ALUCTRL_NONE;
    alu_core #(.W(W)) u_alu (
        .a       (rs_data),
        .b       (c.alusrc ? imm : rt_data),
        .aluctrl (ac),
        .result  (y)
    );
    // zero is registered so that reset forces it low even though result is 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c_q       <= '0;
            aluctrl   <= '0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            c_q       <= c;
            aluctrl   <= ac;
            result    <= y;
            zero      <= y == '0;
        end
    end
    assign {jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop} = c_q;
endmodule

// File: tb/tb_ctrl_alu_stage.sv
// tb_ctrl_alu_stage: table-driven vectors plus reset sequences, checked through an expected-result queue
module tb_ctrl_alu_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid;
    logic [5:0]  op, funct;
    logic [31:0] rs_data, rt_data, imm, result;
    logic        out_valid, zero, jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [3:0]  aluctrl;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic        rn;
        logic        v;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] im;
        logic [9:0]  ctl;
        logic [3:0]  ac;
        logic [31:0] res;
        logic        z;
    } vec_t;
    vec_t tbl[16];
    vec_t exp_q[$];
    ctrl_alu_stage #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .out_valid(out_valid),
        .result(result), .zero(zero), .jump(jump), .regdst(regdst), .alusrc(alusrc),
        .memtoreg(memtoreg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
        .branch(branch), .aluop(aluop), .aluctrl(aluctrl)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic step(input vec_t t);
        vec_t e;
        rst_n = t.rn; in_valid = t.v; op = t.op; funct = t.fn;
        rs_data = t.rs; rt_data = t.rt; imm = t.im;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("op%0h_fn%0h valid", e.op, e.fn), 64'(out_valid), 64'(e.rn & e.v));
        chk($sformatf("op%0h_fn%0h ctrl", e.op, e.fn),
            64'({jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}), 64'(e.ctl));
        chk($sformatf("op%0h_fn%0h aluctrl", e.op, e.fn), 64'(aluctrl), 64'(e.ac));
        chk($sformatf("op%0h_fn%0h result", e.op, e.fn), 64'(result), 64'(e.res));
        chk($sformatf("op%0h_fn%0h zero", e.op, e.fn), 64'(zero), 64'(e.z));
    endtask
    initial begin
        // fields: rn v op fn rs rt imm ctl{j,rd,as,m2r,rw,mr,mw,br,aluop} aluctrl result zero
        tbl[0]  = '{1, 1, 6'h00, 6'h20, 32'd5,        32'd7,        32'h100,      10'b0100100010, 4'b0010, 32'd12,       0};
        tbl[1]  = '{1, 1, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'd0,        10'b0100100010, 4'b0111, 32'd1,        0};
        tbl[2]  = '{1, 1, 6'h00, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'd0,        10'b0100100010, 4'b0111, 32'd0,        1};
        tbl[3]  = '{1, 1, 6'h23, 6'h00, 32'h100,      32'hDEAD,     32'hFFFFFFFC, 10'b0011110000, 4'b0010, 32'hFC,       0};
        tbl[4]  = '{1, 1, 6'h2B, 6'h00, 32'h10,       32'h55,       32'd4,        10'b0010001000, 4'b0010, 32'h14,       0};
        tbl[5]  = '{1, 1, 6'h04, 6'h00, 32'd9,        32'd9,        32'd0,        10'b0000000101, 4'b0110, 32'd0,        1};
        tbl[6]  = '{1, 1, 6'h04, 6'h00, 32'd9,        32'd3,        32'd0,        10'b0000000101, 4'b0110, 32'd6,        0};
        tbl[7]  = '{1, 1, 6'h08, 6'h00, 32'hFFFFFFFF, 32'd50,       32'd1,        10'b0010100000, 4'b0010, 32'd0,        1};
        tbl[8]  = '{1, 1, 6'h02, 6'h00, 32'd3,        32'd4,        32'd5,        10'b1000000000, 4'b0010, 32'd7,        0};
        tbl[9]  = '{1, 1, 6'h3F, 6'h20, 32'd1,        32'd2,        32'd9,        10'b0000000000, 4'b0010, 32'd3,        0};
        tbl[10] = '{1, 1, 6'h00, 6'h3F, 32'd5,        32'd6,        32'd0,        10'b0100100010, 4'b1111, 32'd0,        1};
        tbl[11] = '{1, 1, 6'h00, 6'h22, 32'd3,        32'd5,        32'd0,        10'b0100100010, 4'b0110, 32'hFFFFFFFE, 0};
        tbl[12] = '{1, 1, 6'h00, 6'h24, 32'hF0F0,     32'hFF00,     32'd0,        10'b0100100010, 4'b0000, 32'hF000,     0};
        tbl[13] = '{1, 1, 6'h00, 6'h25, 32'hF0F0,     32'hFF00,     32'd0,        10'b0100100010, 4'b0001, 32'hFFF0,     0};
        tbl[14] = '{1, 1, 6'h00, 6'h27, 32'd0,        32'd0,        32'd0,        10'b0100100010, 4'b1100, 32'hFFFFFFFF, 0};
        tbl[15] = '{1, 0, 6'h00, 6'h20, 32'd1,        32'd1,        32'd0,        10'b0100100010, 4'b0010, 32'd2,        0};
        // reset held with a valid add on the inputs: reset must win
        step('{0, 1, 6'h00, 6'h20, 32'd5, 32'd7, 32'd0, 10'b0, 4'b0, 32'd0, 0});
        step('{0, 1, 6'h00, 6'h20, 32'd5, 32'd7, 32'd0, 10'b0, 4'b0, 32'd0, 0});
        foreach (tbl[i]) step(tbl[i]);
        // reset mid-stream, then one-cycle latency resumes
        step('{1, 1, 6'h00, 6'h20, 32'd20, 32'd22, 32'd0, 10'b0100100010, 4'b0010, 32'd42, 0});
        step('{0, 1, 6'h00, 6'h20, 32'd8,  32'd8,  32'd0, 10'b0,          4'b0,    32'd0,  0});
        step('{1, 1, 6'h00, 6'h22, 32'd10, 32'd4,  32'd0, 10'b0100100010, 4'b0110, 32'd6,  0});
        step('{1, 1, 6'h23, 6'h00, 32'd1,  32'd0,  32'd2, 10'b0011110000, 4'b0010, 32'd3,  0});
        chk("queue drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
